// File: rtl/trace_capture.sv
// trace_capture: timestamped FIFO of core commit events (register writes, memory writes and reads).
// Optional macro TRACE_X0_FILTER_EN: when defined, register writes to x0 are ignored entirely.
`timescale 1ns/1ps
module trace_capture #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reg_write_sig,
  input  logic [4:0]      reg_num,
  input  logic [31:0]     reg_data,
  input  logic            wr,
  input  logic            rd,
  input  logic [8:0]      addr,
  input  logic [31:0]     wr_data,
  input  logic [31:0]     rd_data,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [1:0]      trace_kind,
  output logic [8:0]      trace_tag,
  output logic [31:0]     trace_data,
  output logic [TS_W-1:0] trace_time,
  output logic [15:0]     drop_count,
  output logic            overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 2 + 9 + 32 + TS_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TS_W-1:0] r_ts;
  logic [15:0]     r_drop;
  logic            r_overflow;

  logic            w_reg_ev;
  logic            w_mem_wr;
  logic            w_mem_rd;
  logic            w_mem_ev;
  logic            w_pop;
  logic [CW-1:0]   w_space;
  logic [1:0]      w_n_ev;
  logic [1:0]      w_n_push;
  logic [1:0]      w_n_drop;
  logic [EW-1:0]   w_reg_ent;
  logic [EW-1:0]   w_mem_ent;
  logic [EW-1:0]   w_ent0;
  logic [AW-1:0]   w_wr_ptr1;
  logic [16:0]     w_drop_sum;
  logic [15:0]     w_drop_next;

  // Event decode, space check and push/drop accounting for this cycle.
  always_comb begin
`ifdef TRACE_X0_FILTER_EN
    w_reg_ev = reg_write_sig & (reg_num != 5'd0);
`else
    w_reg_ev = reg_write_sig;
`endif
    w_mem_wr  = wr & ~rd;
    w_mem_rd  = rd & ~wr;
    w_mem_ev  = w_mem_wr | w_mem_rd;
    w_pop     = (r_count != '0) & trace_ready;
    w_space   = DEPTH_C - r_count + CW'(w_pop);
    w_n_ev    = {1'b0, w_reg_ev} + {1'b0, w_mem_ev};
    // Space is at most 1 whenever it is short of the event count.
    if (w_space >= CW'(w_n_ev)) begin
      w_n_push = w_n_ev;
    end else begin
      w_n_push = w_space[1:0];
    end
    w_n_drop  = w_n_ev - w_n_push;
    w_reg_ent = {2'd0, 4'b0000, reg_num, reg_data, r_ts};
    w_mem_ent = {(w_mem_wr ? 2'd1 : 2'd2), addr, (w_mem_wr ? wr_data : rd_data), r_ts};
    w_ent0    = w_reg_ev ? w_reg_ent : w_mem_ent;
    w_wr_ptr1 = r_wr_ptr + AW'(1);
    w_drop_sum  = {1'b0, r_drop} + 17'(w_n_drop);
    w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // Show-ahead head presentation; zeros while empty.
  always_comb begin
    trace_valid = (r_count != '0);
    if (trace_valid) begin
      {trace_kind, trace_tag, trace_data, trace_time} = r_mem[r_rd_ptr];
    end else begin
      {trace_kind, trace_tag, trace_data, trace_time} = '0;
    end
    drop_count = r_drop;
    overflow   = r_overflow;
  end

  // Control state: timestamp, pointers, occupancy and drop statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop     <= 16'h0000;
      r_overflow <= 1'b0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
      r_count  <= r_count + CW'(w_n_push) - CW'(w_pop);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_drop <= w_drop_next;
      if (w_n_drop != 2'd0) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Entry storage; a second push in the same cycle is always the memory event.
  always_ff @(posedge clk) begin
    if (w_n_push != 2'd0) begin
      r_mem[r_wr_ptr] <= w_ent0;
    end
    if (w_n_push == 2'd2) begin
      r_mem[w_wr_ptr1] <= w_mem_ent;
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: reference queue model with drop accounting,
// head/statistics compared every cycle on the falling edge.
`timescale 1ns/1ps
module tb_trace_capture;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            reg_write_sig;
  logic [4:0]      reg_num;
  logic [31:0]     reg_data;
  logic            wr;
  logic            rd;
  logic [8:0]      addr;
  logic [31:0]     wr_data;
  logic [31:0]     rd_data;
  logic            trace_valid;
  logic            trace_ready;
  logic [1:0]      trace_kind;
  logic [8:0]      trace_tag;
  logic [31:0]     trace_data;
  logic [TS_W-1:0] trace_time;
  logic [15:0]     drop_count;
  logic            overflow;

  typedef struct packed {
    logic [1:0]      kind;
    logic [8:0]      tag;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } ent_t;

  ent_t            sb[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [TS_W-1:0] ts_m;
  logic [15:0]     drop_m;
  logic            ovf_m;

  trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_kind(trace_kind), .trace_tag(trace_tag), .trace_data(trace_data),
    .trace_time(trace_time), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_head();
    if (sb.size() == 0) begin
      check_eq("valid_empty", 64'(trace_valid), 64'd0);
      check_eq("kind_empty",  64'(trace_kind),  64'd0);
      check_eq("tag_empty",   64'(trace_tag),   64'd0);
      check_eq("data_empty",  64'(trace_data),  64'd0);
      check_eq("time_empty",  64'(trace_time),  64'd0);
    end else begin
      check_eq("valid", 64'(trace_valid), 64'd1);
      check_eq("kind",  64'(trace_kind),  64'(sb[0].kind));
      check_eq("tag",   64'(trace_tag),   64'(sb[0].tag));
      check_eq("data",  64'(trace_data),  64'(sb[0].data));
      check_eq("time",  64'(trace_time),  64'(sb[0].ts));
    end
    check_eq("drop_count", 64'(drop_count), 64'(drop_m));
    check_eq("overflow",   64'(overflow),   64'(ovf_m));
  endtask

  task automatic model_push(input ent_t e);
    if (sb.size() < DEPTH) begin
      sb.push_back(e);
    end else begin
      if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
      ovf_m = 1'b1;
    end
  endtask

  // One clock: check head at the falling edge, drive inputs, update model, advance.
  task automatic step(input logic rw, input logic [4:0] rn, input logic [31:0] rdat,
                      input logic w, input logic r, input logic [8:0] a,
                      input logic [31:0] wd, input logic [31:0] rdd, input logic rdy);
    ent_t e;
    logic reg_ev;
    check_head();
    reg_write_sig = rw; reg_num = rn; reg_data = rdat;
    wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd; trace_ready = rdy;
    if (rdy && sb.size() > 0) e = sb.pop_front();
`ifdef TRACE_X0_FILTER_EN
    reg_ev = rw && (rn != 5'd0);
`else
    reg_ev = rw;
`endif
    if (reg_ev) begin
      e.kind = 2'd0; e.tag = {4'b0000, rn}; e.data = rdat; e.ts = ts_m;
      model_push(e);
    end
    if (w ^ r) begin
      e.kind = w ? 2'd1 : 2'd2; e.tag = a; e.data = w ? wd : rdd; e.ts = ts_m;
      model_push(e);
    end
    @(posedge clk);
    ts_m = ts_m + TS_W'(1);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, rdy);
  endtask

  initial begin
    reset = 1'b1; reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = 32'd0;
    wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = 32'd0; rd_data = 32'd0; trace_ready = 1'b0;
    ts_m = '0; drop_m = 16'd0; ovf_m = 1'b0;
    @(negedge clk); @(negedge clk);
    check_head();
    reset = 1'b0;

    // Single register write stamped at timestamp 3.
    idle(1'b0); idle(1'b0); idle(1'b0);
    step(1'b1, 5'd5, 32'h0000_002A, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
    check_eq("t1_time", 64'(trace_time), 64'd3);
    idle(1'b1);
    idle(1'b0);

    // Simultaneous register and memory write, consumed back to back.
    step(1'b1, 5'd7, 32'hFFFF_FFFF, 1'b1, 1'b0, 9'd12, 32'h10, 32'd0, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b0);

    // Overflow: 18 reads with no consumer.
    for (int i = 0; i < 18; i++)
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 9'(i + 40), 32'd0, 32'(i * 3 + 1), 1'b0);
    idle(1'b0);
    check_eq("ovf_drops", 64'(drop_count), 64'd2);
    check_eq("ovf_flag",  64'(overflow),   64'd1);

    // Full FIFO: pop plus two events; memory event is dropped.
    step(1'b1, 5'd9, 32'hCAFE_0009, 1'b0, 1'b1, 9'd100, 32'd0, 32'hBEEF, 1'b1);
    idle(1'b0);
    check_eq("full_drops", 64'(drop_count), 64'd3);
    for (int i = 0; i < 17; i++) idle(1'b1);

    // Illegal strobe pair, then a write to x0.
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 9'd3, 32'h33, 32'h44, 1'b0);
    idle(1'b0);
    step(1'b1, 5'd0, 32'h0000_0055, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
    idle(1'b1); idle(1'b0);

    // Randomised traffic with random consumer back-pressure.
    for (int i = 0; i < 120; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 9'($urandom), $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 20; i++) idle(1'b1);

    // Reset while 5 entries are queued, with events held during reset.
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'(i + 1), 32'(i + 100), 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
    #2;
    reset = 1'b1; reg_write_sig = 1'b1; reg_num = 5'd3; wr = 1'b1; rd = 1'b0; addr = 9'd8;
    #1;
    sb.delete(); drop_m = 16'd0; ovf_m = 1'b0; ts_m = '0;
    check_eq("rst_valid", 64'(trace_valid), 64'd0);
    check_eq("rst_drop",  64'(drop_count),  64'd0);
    check_eq("rst_ovf",   64'(overflow),    64'd0);
    check_eq("rst_data",  64'(trace_data),  64'd0);
    @(negedge clk); @(negedge clk);
    check_head();
    reg_write_sig = 1'b0; wr = 1'b0;
    reset = 1'b0;
    idle(1'b0); idle(1'b0);
    step(1'b1, 5'd11, 32'h1234_5678, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
    check_eq("rst_restart_time", 64'(trace_time), 64'd2);
    idle(1'b1); idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
